// File: rtl/fluxo_dados_contador_if.sv
// Control-to-datapath link between the counting control unit and
// fluxo_dados_contador.
//   zera         : synchronous clear of the count
//   registra     : load the limit register from dado
//   conta        : count enable
//   dado         : limit value, sampled only while registra is high
//   fim_contador : combinational end-of-run flag returned to the control unit
// master : the control unit (drives the strobes, reads fim_contador)
// slave  : the datapath (reads the strobes, drives fim_contador)
interface fluxo_dados_contador_if #(
  parameter int WIDTH = 4
);
  logic             zera;
  logic             registra;
  logic             conta;
  logic [WIDTH-1:0] dado;
  logic             fim_contador;

  modport master (
    output zera,
    output registra,
    output conta,
    output dado,
    input  fim_contador
  );

  modport slave (
    input  zera,
    input  registra,
    input  conta,
    input  dado,
    output fim_contador
  );
endinterface

// File: rtl/fluxo_dados_contador.sv
// Counting datapath that sits directly downstream of the counting control
// unit. It holds a programmable limit register, a modulo-(limite+1) up-counter
// and a saturating counter of completed runs, and returns fim_contador to
// the controller with zero latency.
// Ports:
//   clock    : system clock, rising edge
//   reset    : asynchronous, active-low reset
//   ctrl     : control link (zera, registra, conta, dado in; fim_contador out)
//   contagem : current count
//   limite   : current limit
//   voltas   : completed runs, saturating at all-ones
module fluxo_dados_contador #(
  parameter int WIDTH         = 4,
  parameter int LIMITE_PADRAO = 15,
  parameter int VOLTAS_WIDTH  = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  fluxo_dados_contador_if.slave   ctrl,
  output logic [WIDTH-1:0]        contagem,
  output logic [WIDTH-1:0]        limite,
  output logic [VOLTAS_WIDTH-1:0] voltas
);

  localparam logic [WIDTH-1:0] LIMITE_RESET = WIDTH'(LIMITE_PADRAO);

  logic fim;

  // End of run is combinational so the controller can leave its counting
  // state in the same cycle the last count is reached.
  assign fim               = ctrl.conta && (contagem == limite);
  assign ctrl.fim_contador = fim;

  // Count: clear has priority over counting; the wrap compares against the
  // limit currently held, so a limit loaded in the same cycle only applies
  // from the next cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem <= '0;
    end else if (ctrl.zera) begin
      contagem <= '0;
    end else if (fim) begin
      contagem <= '0;
    end else if (ctrl.conta) begin
      contagem <= contagem + 1'b1;
    end
  end

  // Limit register: loaded from dado, independent of zera.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      limite <= LIMITE_RESET;
    end else if (ctrl.registra) begin
      limite <= ctrl.dado;
    end
  end

  // Completed runs: a run only counts if it was not cleared in the same
  // cycle; only reset returns it to zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      voltas <= '0;
    end else if (fim && !ctrl.zera && (voltas != {VOLTAS_WIDTH{1'b1}})) begin
      voltas <= voltas + 1'b1;
    end
  end

endmodule
